// File: rtl/decode_stage_if.sv
// Decode-stage bundle: fetch-side handshake, write-back port and decoded output bundle.
// No logic; the decode stage owns the slave side and the fetch/ALU/write-back environment owns the master side.
// Valid/ready on both sides; write-back is an unconditional enable/address/data strobe.
interface decode_stage_if #(
  parameter int XLEN = 32
);
  // fetch side
  logic            in_vld;
  logic            in_rdy;
  logic [31:0]     inst;
  logic            flush;
  // write-back side
  logic            wb_en;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;
  // ALU side
  logic            out_vld;
  logic            out_rdy;
  logic [5:0]      opcode;
  logic [5:0]      funct;
  logic [4:0]      rs;
  logic [4:0]      rt;
  logic [4:0]      des;
  logic            alu_src;
  logic            reg_write;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;

  modport master (
    output in_vld, inst, flush, wb_en, wb_addr, wb_data, out_rdy,
    input  in_rdy, out_vld, opcode, funct, rs, rt, des, alu_src, reg_write, src_a, src_b
  );

  modport slave (
    input  in_vld, inst, flush, wb_en, wb_addr, wb_data, out_rdy,
    output in_rdy, out_vld, opcode, funct, rs, rt, des, alu_src, reg_write, src_a, src_b
  );
endinterface

// File: rtl/decode_stage.sv
// Instruction decode stage with integrated register file and write-back bypass.
// Latency 1: an instruction accepted at edge N is presented with out_vld=1 after edge N.
// One-entry output register; in_rdy = !out_vld | out_rdy, bundle held stable while stalled (except forwarded operands).
// Ports: i_clk, i_rst_n (async active-low), bus (decode_stage_if.slave):
//   fetch in_vld/in_rdy/inst/flush, write-back wb_en/wb_addr/wb_data,
//   ALU out_vld/out_rdy/opcode/funct/rs/rt/des/alu_src/reg_write/src_a/src_b.
module decode_stage #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter bit SIGN_EXT = 1'b1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  decode_stage_if.slave bus
);

  // One bit per architectural address that is backed by storage. r0 is excluded so it reads as
  // zero and ignores writes; addresses at or above NREGS fall outside the mask the same way.
  localparam logic [31:0] REG_MASK =
    ((NREGS >= 32) ? 32'hFFFF_FFFF : ((32'd1 << NREGS) - 32'd1)) & ~32'd1;

  logic [XLEN-1:0] r_regs [32];

  logic            r_out_vld;
  logic [5:0]      r_opcode;
  logic [5:0]      r_funct;
  logic [4:0]      r_rs;
  logic [4:0]      r_rt;
  logic [4:0]      r_des;
  logic            r_alu_src;
  logic            r_reg_write;
  logic [XLEN-1:0] r_src_a;
  logic [XLEN-1:0] r_src_b;

  logic            w_in_rdy;
  logic            w_accept;
  logic            w_xfer;
  logic            w_wb_hit;
  logic [5:0]      w_op;
  logic [4:0]      w_rs;
  logic [4:0]      w_rt;
  logic [4:0]      w_rd;
  logic [4:0]      w_des;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_rs_val;
  logic [XLEN-1:0] w_rt_val;

  assign w_in_rdy = !r_out_vld || bus.out_rdy;
  assign w_accept = bus.in_vld && w_in_rdy && !bus.flush;
  assign w_xfer   = r_out_vld && bus.out_rdy;
  assign w_wb_hit = bus.wb_en && REG_MASK[bus.wb_addr];

  assign w_op  = bus.inst[31:26];
  assign w_rs  = bus.inst[25:21];
  assign w_rt  = bus.inst[20:16];
  assign w_rd  = bus.inst[15:11];
  assign w_des = (w_op == 6'd0) ? w_rd : w_rt;
  assign w_imm = SIGN_EXT ? XLEN'($signed(bus.inst[15:0])) : XLEN'(bus.inst[15:0]);

  // Operand reads bypass a same-cycle write so the captured value is never stale.
  always_comb begin
    w_rs_val = '0;
    if (REG_MASK[w_rs]) begin
      w_rs_val = (w_wb_hit && (bus.wb_addr == w_rs)) ? bus.wb_data : r_regs[w_rs];
    end
  end

  always_comb begin
    w_rt_val = '0;
    if (REG_MASK[w_rt]) begin
      w_rt_val = (w_wb_hit && (bus.wb_addr == w_rt)) ? bus.wb_data : r_regs[w_rt];
    end
  end

  // Register file: writes are independent of the pipeline state, including flush.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wb_hit) begin
      r_regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Output register. Priority: flush, accept, drain, stalled-hold forwarding.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_vld   <= 1'b0;
      r_opcode    <= '0;
      r_funct     <= '0;
      r_rs        <= '0;
      r_rt        <= '0;
      r_des       <= '0;
      r_alu_src   <= 1'b0;
      r_reg_write <= 1'b0;
      r_src_a     <= '0;
      r_src_b     <= '0;
    end else if (bus.flush) begin
      r_out_vld <= 1'b0;
    end else if (w_accept) begin
      r_out_vld   <= 1'b1;
      r_opcode    <= w_op;
      r_funct     <= bus.inst[5:0];
      r_rs        <= w_rs;
      r_rt        <= w_rt;
      r_des       <= w_des;
      r_alu_src   <= (w_op != 6'd0);
      r_reg_write <= (w_des != 5'd0);
      r_src_a     <= w_rs_val;
      r_src_b     <= (w_op == 6'd0) ? w_rt_val : w_imm;
    end else if (w_xfer) begin
      r_out_vld <= 1'b0;
    end else if (r_out_vld && w_wb_hit) begin
      // Stalled bundle: keep register operands coherent with write-back. The immediate
      // operand (alu_src=1) is not a register value and is left alone.
      if (bus.wb_addr == r_rs) begin
        r_src_a <= bus.wb_data;
      end
      if (!r_alu_src && (bus.wb_addr == r_rt)) begin
        r_src_b <= bus.wb_data;
      end
    end
  end

  assign bus.in_rdy    = w_in_rdy;
  assign bus.out_vld   = r_out_vld;
  assign bus.opcode    = r_opcode;
  assign bus.funct     = r_funct;
  assign bus.rs        = r_rs;
  assign bus.rt        = r_rt;
  assign bus.des       = r_des;
  assign bus.alu_src   = r_alu_src;
  assign bus.reg_write = r_reg_write;
  assign bus.src_a     = r_src_a;
  assign bus.src_b     = r_src_b;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: scoreboard of expected bundles, one task per scenario.
// Main instance: XLEN=32, NREGS=32, SIGN_EXT=1. Second instance: SIGN_EXT=0, NREGS=8.
// Inputs driven 1ns after the rising edge; outputs sampled at the same point.
module tb_decode_stage;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  des;
    logic        alu_src;
    logic        reg_write;
    logic [31:0] src_a;
    logic [31:0] src_b;
  } bund_t;

  logic clk;
  logic rst_n;

  decode_stage_if #(.XLEN(32)) bus ();
  decode_stage_if #(.XLEN(32)) bus2 ();

  decode_stage #(.XLEN(32), .NREGS(32), .SIGN_EXT(1'b1)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus)
  );

  decode_stage #(.XLEN(32), .NREGS(8), .SIGN_EXT(1'b0)) u_dut_zx (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_fail   = 0;
  bund_t sb[$];
  logic [31:0] mref [32];
  logic  mv;

  function automatic bund_t get_out();
    bund_t b;
    b.opcode    = bus.opcode;
    b.funct     = bus.funct;
    b.rs        = bus.rs;
    b.rt        = bus.rt;
    b.des       = bus.des;
    b.alu_src   = bus.alu_src;
    b.reg_write = bus.reg_write;
    b.src_a     = bus.src_a;
    b.src_b     = bus.src_b;
    return b;
  endfunction

  // Reference decode of one instruction against the model register file.
  function automatic bund_t model(input logic [31:0] inst);
    bund_t b;
    logic [31:0] imm;
    b.opcode = inst[31:26];
    b.funct  = inst[5:0];
    b.rs     = inst[25:21];
    b.rt     = inst[20:16];
    imm      = {{16{inst[15]}}, inst[15:0]};
    b.src_a  = mref[b.rs];
    if (b.opcode == 6'd0) begin
      b.alu_src = 1'b0;
      b.des     = inst[15:11];
      b.src_b   = mref[b.rt];
    end else begin
      b.alu_src = 1'b1;
      b.des     = inst[20:16];
      b.src_b   = imm;
    end
    b.reg_write = (b.des != 5'd0);
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mref[i] = '0;
    sb.delete();
    mv = 1'b0;
  endtask

  task automatic drive(input logic iv, input logic [31:0] inst, input logic fl,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic ordy);
    bus.in_vld  = iv;
    bus.inst    = inst;
    bus.flush   = fl;
    bus.wb_en   = we;
    bus.wb_addr = wa;
    bus.wb_data = wd;
    bus.out_rdy = ordy;
  endtask

  // Advance one clock, updating the model from the inputs currently driven.
  task automatic tick();
    logic  w, rdy, acc;
    bund_t t;
    w   = bus.wb_en && (bus.wb_addr != 5'd0);
    rdy = !mv || bus.out_rdy;
    acc = bus.in_vld && rdy && !bus.flush;
    if (bus.flush) begin
      sb.delete();
    end else if (mv && !bus.out_rdy && w && sb.size() > 0) begin
      t = sb[0];
      if (t.rs == bus.wb_addr) t.src_a = bus.wb_data;
      if (!t.alu_src && t.rt == bus.wb_addr) t.src_b = bus.wb_data;
      sb[0] = t;
    end
    if (w) mref[bus.wb_addr] = bus.wb_data;
    if (acc) sb.push_back(model(bus.inst));
    if (bus.flush) mv = 1'b0;
    else if (acc) mv = 1'b1;
    else if (bus.out_rdy) mv = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bund_t got;
    drive(0, 32'h0, 0, 0, 5'd0, 32'h0, 0);
    bus2.in_vld = 0; bus2.inst = 0; bus2.flush = 0; bus2.wb_en = 0;
    bus2.wb_addr = 0; bus2.wb_data = 0; bus2.out_rdy = 0;
    rst_n = 1'b0;
    model_reset();
    #12;
    got = get_out();
    n_checks++;
    if (bus.out_vld !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_vld got=%b exp=0", bus.out_vld);
    end
    n_checks++;
    if (got !== '0) begin
      n_fail++; $display("FAIL reset_bundle got=%h exp=0", got);
    end
    n_checks++;
    if (bus.in_rdy !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_rdy got=%b exp=1", bus.in_rdy);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_rtype();
    bund_t got, exp;
    drive(0, 32'h0, 0, 1, 5'd3, 32'd5, 1); tick();
    drive(0, 32'h0, 0, 1, 5'd4, 32'd7, 1); tick();
    drive(1, 32'h0064_2820, 0, 0, 5'd0, 32'h0, 0); tick();
    n_checks++;
    if (bus.out_vld !== 1'b1) begin
      n_fail++; $display("FAIL rtype_out_vld got=%b exp=1", bus.out_vld);
    end
    n_checks++;
    if (bus.src_a !== 32'd5 || bus.src_b !== 32'd7 || bus.des !== 5'd5 ||
        bus.alu_src !== 1'b0 || bus.reg_write !== 1'b1) begin
      n_fail++;
      $display("FAIL rtype_fields got a=%h b=%h des=%0d alu_src=%b rw=%b exp a=5 b=7 des=5 alu_src=0 rw=1",
               bus.src_a, bus.src_b, bus.des, bus.alu_src, bus.reg_write);
    end
    n_checks++;
    if (bus.in_rdy !== 1'b0) begin
      n_fail++; $display("FAIL rtype_stall_in_rdy got=%b exp=0", bus.in_rdy);
    end
    drive(0, 32'h0, 0, 0, 5'd0, 32'h0, 1);
    got = get_out();
    exp = sb.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_fail++; $display("FAIL rtype_bundle got=%h exp=%h", got, exp);
    end
    tick();
    n_checks++;
    if (bus.out_vld !== 1'b0) begin
      n_fail++; $display("FAIL rtype_drain got=%b exp=0", bus.out_vld);
    end
  endtask

  task automatic test_imm();
    bund_t got, exp;
    drive(1, 32'h2066_FFFC, 0, 0, 5'd0, 32'h0, 1); tick();
    got = get_out();
    exp = sb.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_fail++; $display("FAIL imm_bundle got=%h exp=%h", got, exp);
    end
    n_checks++;
    if (bus.src_b !== 32'hFFFF_FFFC || bus.des !== 5'd6 || bus.alu_src !== 1'b1) begin
      n_fail++;
      $display("FAIL imm_sext got b=%h des=%0d alu_src=%b exp b=fffffffc des=6 alu_src=1",
               bus.src_b, bus.des, bus.alu_src);
    end
    drive(0, 32'h0, 0, 0, 5'd0, 32'h0, 1); tick();
    // Zero-extending, 8-register instance; r9 write is out of range and must be dropped.
    bus2.in_vld = 1; bus2.inst = 32'h2066_FFFC; bus2.out_rdy = 1;
    bus2.wb_en = 1; bus2.wb_addr = 5'd9; bus2.wb_data = 32'h1234;
    @(posedge clk); #1;
    n_checks++;
    if (bus2.out_vld !== 1'b1 || bus2.src_b !== 32'h0000_FFFC || bus2.des !== 5'd6) begin
      n_fail++;
      $display("FAIL imm_zext got vld=%b b=%h des=%0d exp vld=1 b=0000fffc des=6",
               bus2.out_vld, bus2.src_b, bus2.des);
    end
    bus2.in_vld = 0; bus2.wb_en = 1; bus2.wb_addr = 5'd3; bus2.wb_data = 32'h55;
    @(posedge clk); #1;
    bus2.in_vld = 1; bus2.inst = 32'h0123_0820; bus2.wb_en = 0;
    @(posedge clk); #1;
    n_checks++;
    if (bus2.src_a !== 32'h0 || bus2.src_b !== 32'h55) begin
      n_fail++;
      $display("FAIL nregs_range got a=%h b=%h exp a=0 b=55", bus2.src_a, bus2.src_b);
    end
    bus2.in_vld = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_hold_fwd();
    bund_t got, exp;
    drive(1, 32'h0064_2820, 0, 0, 5'd0, 32'h0, 0); tick();
    for (int c = 0; c < 3; c++) begin
      drive(1, 32'h20A5_0001, 0, (c == 1), 5'd3, 32'h99, 0);
      n_checks++;
      if (bus.in_rdy !== 1'b0) begin
        n_fail++; $display("FAIL hold_in_rdy cycle=%0d got=%b exp=0", c, bus.in_rdy);
      end
      tick();
      got = get_out();
      exp = sb[0];
      n_checks++;
      if (bus.out_vld !== 1'b1 || got !== exp) begin
        n_fail++;
        $display("FAIL hold_bundle cycle=%0d got vld=%b %h exp vld=1 %h", c, bus.out_vld, got, exp);
      end
    end
    n_checks++;
    if (bus.src_a !== 32'h99 || bus.src_b !== 32'd7 || bus.des !== 5'd5) begin
      n_fail++;
      $display("FAIL hold_fwd got a=%h b=%h des=%0d exp a=99 b=7 des=5", bus.src_a, bus.src_b, bus.des);
    end
    drive(0, 32'h0, 0, 0, 5'd0, 32'h0, 1);
    got = get_out();
    exp = sb.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_fail++; $display("FAIL hold_release got=%h exp=%h", got, exp);
    end
    tick();
  endtask

  task automatic test_bypass();
    bund_t got, exp;
    drive(1, 32'h0064_2820, 0, 1, 5'd3, 32'h11, 1); tick();
    got = get_out();
    exp = sb.pop_front();
    n_checks++;
    if (got !== exp || bus.src_a !== 32'h11) begin
      n_fail++; $display("FAIL bypass got=%h a=%h exp=%h a=11", got, bus.src_a, exp);
    end
    drive(0, 32'h0, 0, 1, 5'd0, 32'hDEAD, 1); tick();
    drive(1, 32'h0000_0020, 0, 0, 5'd0, 32'h0, 1); tick();
    got = get_out();
    exp = sb.pop_front();
    n_checks++;
    if (got !== exp || bus.src_a !== 32'h0 || bus.src_b !== 32'h0 || bus.reg_write !== 1'b0) begin
      n_fail++;
      $display("FAIL r0_zero got=%h a=%h b=%h rw=%b exp=%h a=0 b=0 rw=0",
               got, bus.src_a, bus.src_b, bus.reg_write, exp);
    end
    drive(0, 32'h0, 0, 0, 5'd0, 32'h0, 1); tick();
  endtask

  task automatic test_flush();
    bund_t got, exp;
    drive(1, 32'h0064_2820, 0, 0, 5'd0, 32'h0, 0); tick();
    // in_rdy is high here, so only the flush can keep the new instruction out.
    drive(1, 32'h00E0_0820, 1, 1, 5'd7, 32'h77, 1); tick();
    n_checks++;
    if (bus.out_vld !== 1'b0) begin
      n_fail++; $display("FAIL flush_out_vld got=%b exp=0", bus.out_vld);
    end
    drive(0, 32'h0, 0, 0, 5'd0, 32'h0, 1); tick();
    n_checks++;
    if (bus.out_vld !== 1'b0) begin
      n_fail++; $display("FAIL flush_no_capture got=%b exp=0", bus.out_vld);
    end
    drive(1, 32'h00E0_0820, 0, 0, 5'd0, 32'h0, 1); tick();
    got = get_out();
    exp = sb.pop_front();
    n_checks++;
    if (got !== exp || bus.src_a !== 32'h77 || bus.des !== 5'd1) begin
      n_fail++; $display("FAIL flush_wb_kept got=%h a=%h exp=%h a=77 des=1", got, bus.src_a, exp);
    end
    drive(0, 32'h0, 0, 0, 5'd0, 32'h0, 1); tick();
  endtask

  task automatic test_back_to_back();
    bund_t got, exp;
    int    n_vld;
    logic [31:0] inst;
    for (int i = 1; i < 10; i++) begin
      drive(0, 32'h0, 0, 1, 5'(i), 32'h100 + 32'(i), 1); tick();
    end
    n_vld = 0;
    for (int i = 0; i < 8; i++) begin
      inst = (32'(i + 1) << 21) | (32'(i + 2) << 16) | (32'(i + 3) << 11) | 32'h20;
      drive(1, inst, 0, 0, 5'd0, 32'h0, 1); tick();
      if (bus.out_vld === 1'b1) n_vld++;
      got = get_out();
      exp = sb.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++; $display("FAIL b2b_bundle idx=%0d got=%h exp=%h", i, got, exp);
      end
    end
    n_checks++;
    if (n_vld != 8) begin
      n_fail++; $display("FAIL b2b_count got=%0d exp=8", n_vld);
    end
    drive(0, 32'h0, 0, 0, 5'd0, 32'h0, 1); tick();
    n_checks++;
    if (bus.out_vld !== 1'b0) begin
      n_fail++; $display("FAIL b2b_drain got=%b exp=0", bus.out_vld);
    end
    // Reset in the middle of a stream.
    drive(1, 32'h0064_2820, 0, 0, 5'd0, 32'h0, 1); tick();
    void'(sb.pop_front());
    tick();
    void'(sb.pop_front());
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out_vld !== 1'b0) begin
      n_fail++; $display("FAIL async_reset got=%b exp=0", bus.out_vld);
    end
    model_reset();
    drive(0, 32'h0, 0, 0, 5'd0, 32'h0, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1, 32'h0064_2820, 0, 0, 5'd0, 32'h0, 1); tick();
    got = get_out();
    exp = sb.pop_front();
    n_checks++;
    if (got !== exp || bus.src_a !== 32'h0) begin
      n_fail++; $display("FAIL reset_clears_regs got=%h a=%h exp=%h a=0", got, bus.src_a, exp);
    end
    drive(0, 32'h0, 0, 0, 5'd0, 32'h0, 1); tick();
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_imm();
    test_hold_fwd();
    test_bypass();
    test_flush();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
